// File: rtl/led_pkg.sv
// Shared types and constants for the 16x16 bicolour LED board scan path.
package led_pkg;
  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned NUM_COLS = 16;

  typedef logic [15:0][15:0] pixel_frame_t;
  typedef enum logic {BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/led_row_timer.sv
// Row/dwell counters with BLANK/DRIVE decode; shared by scan-driven consumers.
module led_row_timer
  import led_pkg::*;
#(
  parameter int unsigned CLKS_PER_ROW = 2064,
  parameter int unsigned BLANK_CLKS   = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  output logic [$clog2(NUM_ROWS)-1:0]     row,
  output logic [$clog2(CLKS_PER_ROW)-1:0] dwell_off,
  output scan_state_t                     state,
  output logic                            frame_start
);
  localparam int unsigned DW = $clog2(CLKS_PER_ROW);
  localparam int unsigned RW = $clog2(NUM_ROWS);

  logic [DW-1:0] r_dwell;
  logic [RW-1:0] r_row;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else if (r_dwell == DW'(CLKS_PER_ROW - 1)) begin
      r_dwell <= '0;
      r_row   <= r_row + RW'(1);
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // dwell_off wraps during BLANK; consumers only use it while DRIVE.
  always_comb begin
    row         = r_row;
    dwell_off   = r_dwell - DW'(BLANK_CLKS);
    state       = (r_dwell < DW'(BLANK_CLKS)) ? BLANK : DRIVE;
    frame_start = (r_row == '0) && (r_dwell == '0);
  end
endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver: per-frame shadow latch, blanking gap and
// 16-level PWM brightness, all outputs registered.
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int unsigned CLKS_PER_ROW = 2064,
  parameter int unsigned BLANK_CLKS   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [15:0][15:0]   RedPixels,
  input  logic [15:0][15:0]   GrnPixels,
  input  logic [3:0]          Bright,
  output logic [NUM_ROWS-1:0] RowSink,
  output logic [NUM_COLS-1:0] RedCol,
  output logic [NUM_COLS-1:0] GrnCol,
  output logic                FrameStart
);
  localparam int unsigned DW   = $clog2(CLKS_PER_ROW);
  localparam int unsigned CW   = DW + 5;
  localparam int unsigned STEP = (CLKS_PER_ROW - BLANK_CLKS) / 16;

  logic [$clog2(NUM_ROWS)-1:0] w_row;
  logic [DW-1:0]               w_dwell_off;
  scan_state_t                 w_state;
  logic                        w_frame_start;
  logic [CW-1:0]               w_limit;
  logic                        w_lit;

  pixel_frame_t r_shRed;
  pixel_frame_t r_shGrn;
  logic [3:0]   r_shBright;

  led_row_timer #(
    .CLKS_PER_ROW (CLKS_PER_ROW),
    .BLANK_CLKS   (BLANK_CLKS)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .row         (w_row),
    .dwell_off   (w_dwell_off),
    .state       (w_state),
    .frame_start (w_frame_start)
  );

  // Compare carried 5 bits wider than dwell so STEP*16 never overflows.
  always_comb begin
    w_limit = CW'(STEP) * (CW'(r_shBright) + CW'(1));
    w_lit   = (w_state == DRIVE) && ({5'b0, w_dwell_off} < w_limit);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shRed    <= '0;
      r_shGrn    <= '0;
      r_shBright <= '0;
      RowSink    <= '0;
      RedCol     <= '0;
      GrnCol     <= '0;
      FrameStart <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_shRed    <= RedPixels;
        r_shGrn    <= GrnPixels;
        r_shBright <= Bright;
      end
      FrameStart <= w_frame_start;
      if (w_lit) begin
        RowSink <= NUM_ROWS'(1) << w_row;
        RedCol  <= r_shRed[w_row];
        GrnCol  <= r_shGrn[w_row];
      end else begin
        RowSink <= '0;
        RedCol  <= '0;
        GrnCol  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed self-checking bench for led_matrix_scan with a 20-cycle row
// (4 blank + 16 drive, one cycle per brightness step).
module tb_led_matrix_scan;
  logic              CLK;
  logic              RST;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [3:0]        Bright;
  logic [15:0]       RowSink;
  logic [15:0]       RedCol;
  logic [15:0]       GrnCol;
  logic              FrameStart;

  int errors = 0;
  int checks = 0;
  int pos    = 0;  // frame position whose result the outputs currently show

  led_matrix_scan #(
    .CLKS_PER_ROW (20),
    .BLANK_CLKS   (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RedPixels  (RedPixels),
    .GrnPixels  (GrnPixels),
    .Bright     (Bright),
    .RowSink    (RowSink),
    .RedCol     (RedCol),
    .GrnCol     (GrnCol),
    .FrameStart (FrameStart)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    pos = (pos + 1) % 320;
  endtask

  task automatic goto(input int p);
    while (pos != p) tick();
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    tick();
    while (FrameStart !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (FrameStart !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_wait: FrameStart=%b expected 1 within 400 cycles", FrameStart);
    end
    pos = 0;
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    RedPixels = '1;
    GrnPixels = '1;
    Bright    = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({RowSink, RedCol, GrnCol} !== 48'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h/%h/%h expected 0/0/0", RowSink, RedCol, GrnCol);
      end
      checks++;
      if (FrameStart !== 1'b0) begin
        errors++;
        $display("FAIL reset_framestart: got %b expected 0", FrameStart);
      end
    end
    RST = 1'b0;
    tick();
    pos = 0;
    checks++;
    if (FrameStart !== 1'b1) begin
      errors++;
      $display("FAIL release_framestart: got %b expected 1", FrameStart);
    end
    checks++;
    if (RowSink !== 16'h0) begin
      errors++;
      $display("FAIL release_rowsink: got %h expected 0000", RowSink);
    end
    tick();
    checks++;
    if (FrameStart !== 1'b0) begin
      errors++;
      $display("FAIL framestart_single: got %b expected 0", FrameStart);
    end
  endtask

  task automatic test_full_brightness();
    logic [15:0] exp_row;
    logic [15:0] exp_red;
    int r, d, on10;
    RedPixels     = '0;
    GrnPixels     = '0;
    RedPixels[10] = 16'hFE00;
    Bright        = 4'd15;
    wait_frame_start();
    on10 = 0;
    for (int i = 1; i < 320; i++) begin
      tick();
      r = pos / 20;
      d = pos % 20;
      exp_row = (d >= 4) ? (16'h0001 << r) : 16'h0000;
      exp_red = (d >= 4 && r == 10) ? 16'hFE00 : 16'h0000;
      checks++;
      if (RowSink !== exp_row) begin
        errors++;
        $display("FAIL full_rowsink r%0d d%0d: got %h expected %h", r, d, RowSink, exp_row);
      end
      checks++;
      if (RedCol !== exp_red) begin
        errors++;
        $display("FAIL full_redcol r%0d d%0d: got %h expected %h", r, d, RedCol, exp_red);
      end
      checks++;
      if (GrnCol !== 16'h0) begin
        errors++;
        $display("FAIL full_grncol r%0d d%0d: got %h expected 0000", r, d, GrnCol);
      end
      checks++;
      if (FrameStart !== 1'b0) begin
        errors++;
        $display("FAIL full_framestart_mid r%0d d%0d: got %b expected 0", r, d, FrameStart);
      end
      if (r == 10 && RowSink == 16'h0400 && RedCol == 16'hFE00) on10++;
    end
    checks++;
    if (on10 != 16) begin
      errors++;
      $display("FAIL full_row10_ontime: got %0d expected 16", on10);
    end
    tick();
    checks++;
    if (FrameStart !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: FrameStart=%b expected 1 after 320 cycles", FrameStart);
    end
  endtask

  task automatic test_pwm();
    logic [15:0] exp_grn;
    int d, on;
    RedPixels    = '0;
    GrnPixels    = '0;
    GrnPixels[0] = 16'hFFFF;
    Bright       = 4'd3;
    wait_frame_start();
    on = 0;
    for (int i = 0; i < 20; i++) begin
      d = pos % 20;
      exp_grn = (d >= 4 && d < 8) ? 16'hFFFF : 16'h0000;
      checks++;
      if (GrnCol !== exp_grn) begin
        errors++;
        $display("FAIL pwm_grncol d%0d: got %h expected %h", d, GrnCol, exp_grn);
      end
      if (GrnCol == 16'hFFFF) on++;
      tick();
    end
    checks++;
    if (on != 4) begin
      errors++;
      $display("FAIL pwm_ontime: got %0d expected 4", on);
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] exp_red;
    int d;
    RedPixels     = '0;
    GrnPixels     = '0;
    RedPixels[12] = 16'hFE00;
    Bright        = 4'd15;
    wait_frame_start();
    goto(110);
    RedPixels[12] = 16'h0001;
    goto(240);
    for (int i = 0; i < 20; i++) begin
      d = pos % 20;
      exp_red = (d >= 4) ? 16'hFE00 : 16'h0000;
      checks++;
      if (RedCol !== exp_red) begin
        errors++;
        $display("FAIL tear_old_frame d%0d: got %h expected %h", d, RedCol, exp_red);
      end
      tick();
    end
    wait_frame_start();
    goto(240);
    for (int i = 0; i < 20; i++) begin
      d = pos % 20;
      exp_red = (d >= 4) ? 16'h0001 : 16'h0000;
      checks++;
      if (RedCol !== exp_red) begin
        errors++;
        $display("FAIL tear_new_frame d%0d: got %h expected %h", d, RedCol, exp_red);
      end
      tick();
    end
  endtask

  task automatic test_bright_latch();
    int on;
    RedPixels    = '0;
    GrnPixels    = '0;
    RedPixels[8] = 16'hFFFF;
    Bright       = 4'd15;
    wait_frame_start();
    goto(60);
    Bright = 4'd0;
    goto(160);
    on = 0;
    for (int i = 0; i < 20; i++) begin
      if (RowSink != 16'h0) on++;
      tick();
    end
    checks++;
    if (on != 16) begin
      errors++;
      $display("FAIL latch_old_ontime: got %0d expected 16", on);
    end
    wait_frame_start();
    goto(160);
    on = 0;
    for (int i = 0; i < 20; i++) begin
      if (RowSink != 16'h0) on++;
      if (pos == 164) begin
        checks++;
        if (RowSink !== 16'h0100 || RedCol !== 16'hFFFF) begin
          errors++;
          $display("FAIL latch_dim_cycle: got %h/%h expected 0100/ffff", RowSink, RedCol);
        end
      end
      tick();
    end
    checks++;
    if (on != 1) begin
      errors++;
      $display("FAIL latch_new_ontime: got %0d expected 1", on);
    end
  endtask

  task automatic test_reset_mid_row();
    int multi;
    RedPixels    = '0;
    GrnPixels    = '0;
    RedPixels[7] = 16'h00FF;
    Bright       = 4'd15;
    wait_frame_start();
    goto(149);
    checks++;
    if (RowSink !== 16'h0080 || RedCol !== 16'h00FF) begin
      errors++;
      $display("FAIL midrow_before: got %h/%h expected 0080/00ff", RowSink, RedCol);
    end
    RST          = 1'b1;
    RedPixels    = '0;
    RedPixels[0] = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({RowSink, RedCol, GrnCol, FrameStart} !== 49'h0) begin
        errors++;
        $display("FAIL midrow_reset: got %h/%h/%h/%b expected all 0", RowSink, RedCol, GrnCol, FrameStart);
      end
    end
    RST = 1'b0;
    tick();
    pos = 0;
    checks++;
    if (FrameStart !== 1'b1) begin
      errors++;
      $display("FAIL midrow_restart_fs: got %b expected 1", FrameStart);
    end
    multi = 0;
    for (int i = 1; i < 320; i++) begin
      tick();
      if ($countones(RowSink) > 1) multi++;
      if (pos == 4) begin
        checks++;
        if (RowSink !== 16'h0001 || RedCol !== 16'h1234) begin
          errors++;
          $display("FAIL midrow_row0: got %h/%h expected 0001/1234", RowSink, RedCol);
        end
      end
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL midrow_multihot: got %0d multi-hot cycles expected 0", multi);
    end
  endtask

  initial begin
    RST       = 1'b1;
    RedPixels = '0;
    GrnPixels = '0;
    Bright    = '0;
    test_reset();
    test_full_brightness();
    test_pwm();
    test_tear_free();
    test_bright_latch();
    test_reset_mid_row();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
